// File: rtl/board_clear_engine_if.sv
// Command/status bundle between the game control FSM (master) and the playfield
// engine (slave), plus the display row-read port.
interface board_clear_engine_if #(
    parameter int unsigned ROWS  = 20,
    parameter int unsigned COLS  = 10,
    parameter int unsigned ROW_W = 5,
    parameter int unsigned COL_W = 4
) ();
    logic             renew2;
    logic             remove;
    logic             board_clr;
    logic [ROW_W-1:0] piece_y;
    logic [COL_W-1:0] piece_x;
    logic [15:0]      piece_mask;
    logic [ROW_W-1:0] rd_row;
    logic [COLS-1:0]  rd_data;
    logic             shift_finish;
    logic             remove_finish;
    logic             die_true;
    logic             busy;
    logic [2:0]       last_clear;
    logic [15:0]      lines_total;

    modport master (
        output renew2, remove, board_clr, piece_y, piece_x, piece_mask, rd_row,
        input  rd_data, shift_finish, remove_finish, die_true, busy, last_clear, lines_total
    );

    modport slave (
        input  renew2, remove, board_clr, piece_y, piece_x, piece_mask, rd_row,
        output rd_data, shift_finish, remove_finish, die_true, busy, last_clear, lines_total
    );
endinterface

// File: rtl/board_clear_engine.sv
// Playfield occupancy board: merges locked pieces one mask row per cycle and
// collapses full lines bottom-up one row test per cycle.
module board_clear_engine #(
    parameter int unsigned ROWS  = 20,
    parameter int unsigned COLS  = 10,
    parameter int unsigned ROW_W = 5,
    parameter int unsigned COL_W = 4
) (
    input logic                 clk,
    input logic                 clr,
    board_clear_engine_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StMerge, StScan, StDone} state_e;

    state_e                     state_q, state_d;
    logic [ROWS-1:0][COLS-1:0]  board_q, board_d;
    logic [1:0]                 idx_q, idx_d;
    logic [ROW_W-1:0]           row_q, row_d;
    logic [2:0]                 cnt_q, cnt_d;
    logic [ROW_W-1:0]           py_q, py_d;
    logic [COL_W-1:0]           px_q, px_d;
    logic [15:0]                mask_q, mask_d;
    logic [COLS-1:0]            rd_data_q, rd_data_d;
    logic                       shift_finish_q, shift_finish_d;
    logic                       remove_finish_q, remove_finish_d;
    logic                       die_true_q, die_true_d;
    logic [2:0]                 last_clear_q, last_clear_d;
    logic [15:0]                lines_total_q, lines_total_d;

    logic [3:0]                 mask_row;
    logic [COLS-1:0]            merge_bits;
    logic [COLS-1:0]            scan_row;
    logic                       scan_full;

    // Current mask row placed at its board columns; bits past the right edge vanish.
    always_comb begin
        mask_row = '0;
        for (int i = 0; i < 4; i++) begin
            if (int'(idx_q) == i) begin
                mask_row = mask_q[4*i +: 4];
            end
        end
        merge_bits = '0;
        for (int c = 0; c < int'(COLS); c++) begin
            for (int j = 0; j < 4; j++) begin
                if (int'(px_q) + j == c) begin
                    merge_bits[c] = mask_row[j];
                end
            end
        end
    end

    always_comb begin
        scan_row = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            if (int'(row_q) == r) begin
                scan_row = board_q[r];
            end
        end
        scan_full = &scan_row;
    end

    always_comb begin
        state_d         = state_q;
        board_d         = board_q;
        idx_d           = idx_q;
        row_d           = row_q;
        cnt_d           = cnt_q;
        py_d            = py_q;
        px_d            = px_q;
        mask_d          = mask_q;
        last_clear_d    = last_clear_q;
        lines_total_d   = lines_total_q;
        shift_finish_d  = 1'b0;
        remove_finish_d = 1'b0;
        die_true_d      = |board_q[0];

        rd_data_d = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            if (int'(bus.rd_row) == r) begin
                rd_data_d = board_q[r];
            end
        end

        if (bus.board_clr) begin
            state_d       = StIdle;
            board_d       = '0;
            idx_d         = '0;
            row_d         = '0;
            cnt_d         = '0;
            last_clear_d  = '0;
            lines_total_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.renew2) begin
                        py_d    = bus.piece_y;
                        px_d    = bus.piece_x;
                        mask_d  = bus.piece_mask;
                        idx_d   = '0;
                        state_d = StMerge;
                    end else if (bus.remove && !remove_finish_q) begin
                        // remove_finish_q high means this is the stale level from the scan just done
                        row_d   = ROW_W'(ROWS - 1);
                        cnt_d   = '0;
                        state_d = StScan;
                    end
                end
                StMerge: begin
                    for (int r = 0; r < int'(ROWS); r++) begin
                        if (int'(py_q) + int'(idx_q) == r) begin
                            board_d[r] = board_q[r] | merge_bits;
                        end
                    end
                    if (idx_q == 2'd3) begin
                        shift_finish_d = 1'b1;
                        idx_d          = '0;
                        state_d        = StIdle;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
                StScan: begin
                    if (scan_full) begin
                        // Collapse everything above onto the full row, then retest it.
                        for (int k = 1; k < int'(ROWS); k++) begin
                            if (k <= int'(row_q)) begin
                                board_d[k] = board_q[k-1];
                            end
                        end
                        board_d[0] = '0;
                        if (cnt_q != 3'd4) begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else if (row_q == '0) begin
                        state_d = StDone;
                    end else begin
                        row_d = row_q - 1'b1;
                    end
                end
                StDone: begin
                    remove_finish_d = 1'b1;
                    last_clear_d    = cnt_q;
                    lines_total_d   = lines_total_q + {13'd0, cnt_q};
                    row_d           = '0;
                    state_d         = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q         <= StIdle;
            board_q         <= '0;
            idx_q           <= '0;
            row_q           <= '0;
            cnt_q           <= '0;
            py_q            <= '0;
            px_q            <= '0;
            mask_q          <= '0;
            rd_data_q       <= '0;
            shift_finish_q  <= 1'b0;
            remove_finish_q <= 1'b0;
            die_true_q      <= 1'b0;
            last_clear_q    <= '0;
            lines_total_q   <= '0;
        end else begin
            state_q         <= state_d;
            board_q         <= board_d;
            idx_q           <= idx_d;
            row_q           <= row_d;
            cnt_q           <= cnt_d;
            py_q            <= py_d;
            px_q            <= px_d;
            mask_q          <= mask_d;
            rd_data_q       <= rd_data_d;
            shift_finish_q  <= shift_finish_d;
            remove_finish_q <= remove_finish_d;
            die_true_q      <= die_true_d;
            last_clear_q    <= last_clear_d;
            lines_total_q   <= lines_total_d;
        end
    end

    assign bus.rd_data       = rd_data_q;
    assign bus.shift_finish  = shift_finish_q;
    assign bus.remove_finish = remove_finish_q;
    assign bus.die_true      = die_true_q;
    assign bus.busy          = (state_q != StIdle);
    assign bus.last_clear    = last_clear_q;
    assign bus.lines_total   = lines_total_q;

endmodule

// File: tb/tb_board_clear_engine.sv
// Self-checking bench for board_clear_engine: vector table, corner sequences and
// random lock/remove/wipe traffic checked against a row-list board model.
module tb_board_clear_engine;

    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int FULL = (1 << COLS) - 1;

    logic clk = 1'b0;
    logic clr = 1'b1;

    board_clear_engine_if #(.ROWS(ROWS), .COLS(COLS), .ROW_W(5), .COL_W(4)) bus ();

    board_clear_engine #(.ROWS(ROWS), .COLS(COLS), .ROW_W(5), .COL_W(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int unsigned mboard [ROWS];
    int unsigned m_lines = 0;
    int unsigned m_last  = 0;

    typedef struct {
        logic [4:0]  y;
        logic [3:0]  x;
        logic [15:0] mask;
        logic [9:0]  exp_a;
        logic [9:0]  exp_b;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.shift_finish && bus.remove_finish) begin
            checks++;
            errors++;
            $display("FAIL both_finish: got 1 expected 0");
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        foreach (mboard[r]) mboard[r] = 0;
        m_lines = 0;
        m_last  = 0;
    endtask

    task automatic model_merge(input int y, input int x, input logic [15:0] m);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (m[4*i+j] && (y + i) < ROWS && (x + j) < COLS)
                    mboard[y+i] |= (1 << (x + j));
    endtask

    // Keep non-full rows in bottom-up order and let them fall to the floor.
    task automatic model_clear(output int nfull);
        int unsigned kept [$];
        nfull = 0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (mboard[r] == FULL) nfull++;
            else kept.push_back(mboard[r]);
        end
        for (int r = ROWS - 1; r >= 0; r--) begin
            int k;
            k = ROWS - 1 - r;
            mboard[r] = (k < kept.size()) ? kept[k] : 0;
        end
        m_last  = (nfull > 4) ? 4 : nfull;
        m_lines = (m_lines + m_last) & 16'hFFFF;
    endtask

    task automatic read_row(input int r, output logic [9:0] d);
        bus.rd_row = 5'(r);
        tick();
        d = bus.rd_data;
    endtask

    task automatic check_board();
        logic [9:0] d;
        for (int r = 0; r <= ROWS; r++) begin
            read_row(r, d);
            chk($sformatf("board_row%0d", r), 32'(d), (r < ROWS) ? mboard[r] : 0);
        end
        bus.rd_row = '0;
        chk("die_true", 32'(bus.die_true), 32'(mboard[0] != 0));
    endtask

    task automatic do_lock(input logic [4:0] y, input logic [3:0] x, input logic [15:0] m);
        int n;
        bus.piece_y    = y;
        bus.piece_x    = x;
        bus.piece_mask = m;
        bus.renew2     = 1'b1;
        tick();
        bus.renew2 = 1'b0;
        chk("busy_merge", 32'(bus.busy), 1);
        n = 1;
        while (!bus.shift_finish && n < 50) begin
            tick();
            n++;
        end
        chk("shift_latency", n, 5);
        chk("busy_after_merge", 32'(bus.busy), 0);
        model_merge(int'(y), int'(x), m);
    endtask

    task automatic do_remove(input bit hold_extra);
        int n, nfull;
        model_clear(nfull);
        bus.remove = 1'b1;
        tick();
        n = 1;
        while (!bus.remove_finish && n < 100) begin
            tick();
            n++;
        end
        chk("scan_latency", n, ROWS + nfull + 2);
        chk("last_clear", 32'(bus.last_clear), m_last);
        chk("lines_total", 32'(bus.lines_total), m_lines);
        if (!hold_extra) bus.remove = 1'b0;
        tick();
        bus.remove = 1'b0;
        chk("remove_finish_pulse", 32'(bus.remove_finish), 0);
        chk("busy_after_scan", 32'(bus.busy), 0);
    endtask

    task automatic wipe();
        bus.board_clr = 1'b1;
        tick();
        bus.board_clr = 1'b0;
        model_reset();
        chk("wipe_lines", 32'(bus.lines_total), 0);
        chk("wipe_last", 32'(bus.last_clear), 0);
        chk("wipe_busy", 32'(bus.busy), 0);
    endtask

    task automatic fill_row(input logic [4:0] r);
        do_lock(r, 4'd0, 16'h000F);
        do_lock(r, 4'd4, 16'h000F);
        do_lock(r, 4'd8, 16'h0003);
    endtask

    initial begin
        logic [9:0] d;
        int seen;

        vecs[0] = '{5'd18, 4'd0,  16'h000F, 10'h00F, 10'h000};
        vecs[1] = '{5'd19, 4'd8,  16'h0033, 10'h300, 10'h000};
        vecs[2] = '{5'd0,  4'd3,  16'h00F0, 10'h000, 10'h078};
        vecs[3] = '{5'd5,  4'd7,  16'h1111, 10'h080, 10'h080};
        vecs[4] = '{5'd10, 4'd9,  16'h00FF, 10'h200, 10'h200};
        vecs[5] = '{5'd2,  4'd12, 16'hFFFF, 10'h000, 10'h000};

        bus.renew2 = 0; bus.remove = 0; bus.board_clr = 0;
        bus.piece_y = 0; bus.piece_x = 0; bus.piece_mask = 0; bus.rd_row = 0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_data", 32'(bus.rd_data), 0);
        chk("rst_shift_finish", 32'(bus.shift_finish), 0);
        chk("rst_remove_finish", 32'(bus.remove_finish), 0);
        chk("rst_die_true", 32'(bus.die_true), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_last_clear", 32'(bus.last_clear), 0);
        chk("rst_lines_total", 32'(bus.lines_total), 0);
        clr = 1'b0;
        tick();

        foreach (vecs[v]) begin
            wipe();
            do_lock(vecs[v].y, vecs[v].x, vecs[v].mask);
            read_row(int'(vecs[v].y), d);
            chk($sformatf("vec%0d_row_a", v), 32'(d), 32'(vecs[v].exp_a));
            read_row(int'(vecs[v].y) + 1, d);
            chk($sformatf("vec%0d_row_b", v), 32'(d), 32'(vecs[v].exp_b));
            chk($sformatf("vec%0d_die", v), 32'(bus.die_true), 32'(vecs[v].y == 0 && vecs[v].exp_a != 0));
        end

        // Two separated full rows with partial rows between and above.
        wipe();
        fill_row(5'd19);
        fill_row(5'd17);
        do_lock(5'd18, 4'd0, 16'h0001);
        do_lock(5'd16, 4'd4, 16'h000F);
        do_lock(5'd16, 4'd8, 16'h0003);
        do_remove(1'b1);
        read_row(19, d); chk("twoclr_row19", 32'(d), 32'h001);
        read_row(18, d); chk("twoclr_row18", 32'(d), 32'h3F0);
        chk("twoclr_last", 32'(bus.last_clear), 2);
        chk("twoclr_total", 32'(bus.lines_total), 2);
        check_board();

        // Tetris, then an empty scan.
        for (int r = 16; r < 20; r++) fill_row(5'(r));
        do_remove(1'b0);
        chk("tetris_last", 32'(bus.last_clear), 4);
        check_board();
        do_remove(1'b0);
        chk("empty_last", 32'(bus.last_clear), 0);
        chk("empty_total", 32'(bus.lines_total), 6);

        // die_true lags a row-0 write by one cycle; wipe clears it two cycles on.
        bus.piece_y = 0; bus.piece_x = 0; bus.piece_mask = 16'h0001;
        bus.renew2 = 1'b1;
        tick();
        bus.renew2 = 1'b0;
        tick();
        chk("die_lag", 32'(bus.die_true), 0);
        tick();
        chk("die_rise", 32'(bus.die_true), 1);
        tick();
        tick();
        chk("die_shift_finish", 32'(bus.shift_finish), 1);
        model_merge(0, 0, 16'h0001);
        bus.board_clr = 1'b1;
        tick();
        bus.board_clr = 1'b0;
        chk("die_wipe_lag", 32'(bus.die_true), 1);
        chk("die_wipe_total", 32'(bus.lines_total), 0);
        tick();
        chk("die_wipe_fall", 32'(bus.die_true), 0);
        model_reset();

        // Wipe in the middle of a merge aborts it silently.
        do_lock(5'd19, 4'd0, 16'h000F);
        bus.piece_y = 5'd10; bus.piece_mask = 16'hFFFF;
        bus.renew2 = 1'b1;
        tick();
        bus.renew2 = 1'b0;
        tick();
        bus.board_clr = 1'b1;
        tick();
        bus.board_clr = 1'b0;
        model_reset();
        chk("abort_merge_busy", 32'(bus.busy), 0);
        seen = 0;
        repeat (6) begin
            tick();
            if (bus.shift_finish) seen++;
        end
        chk("abort_merge_no_finish", seen, 0);
        check_board();

        // Asynchronous reset in the middle of a scan.
        fill_row(5'd19);
        fill_row(5'd18);
        bus.remove = 1'b1;
        repeat (5) tick();
        #2 clr = 1'b1;
        #1;
        chk("clr_rd_data", 32'(bus.rd_data), 0);
        chk("clr_shift_finish", 32'(bus.shift_finish), 0);
        chk("clr_remove_finish", 32'(bus.remove_finish), 0);
        chk("clr_busy", 32'(bus.busy), 0);
        chk("clr_last", 32'(bus.last_clear), 0);
        chk("clr_total", 32'(bus.lines_total), 0);
        bus.remove = 1'b0;
        clr = 1'b0;
        model_reset();
        seen = 0;
        repeat (3) begin
            tick();
            if (bus.remove_finish) seen++;
        end
        chk("clr_no_finish", seen, 0);
        check_board();
        do_remove(1'b0);

        // Random traffic.
        for (int it = 0; it < 40; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 6)
                do_lock(5'($urandom_range(0, 23)), 4'($urandom_range(0, 15)), 16'($urandom));
            else if (op < 9)
                do_remove(1'b0);
            else
                wipe();
            check_board();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
